// File: rtl/instr_mem_pkg.sv
// Shared types and helpers for the instruction memory bank.
package instr_mem_pkg;

    typedef logic [31:0] word_t;

    typedef struct packed {
        logic  valid;
        logic  err;
        word_t data;
    } imem_resp_t;

    localparam int unsigned IMEM_MAX_LATENCY = 4;

    // Misaligned, below the base, or past the last word.
    function automatic logic imem_addr_err(input word_t addr, input word_t base,
                                           input int unsigned depth);
        word_t off;
        off = addr - base;
        return (addr[1:0] != 2'b00) || (addr < base) || ((off >> 2) >= depth);
    endfunction

endpackage

// File: rtl/instr_mem_resp_pipe.sv
// Response delay line; only the valid bits are reset, payload advances with its valid.
module instr_mem_resp_pipe
    import instr_mem_pkg::*;
#(
    parameter int unsigned STAGES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  imem_resp_t resp_in,
    output imem_resp_t resp_out
);

    if (STAGES == 0) begin : g_bypass
        logic unused_clk;
        assign unused_clk = clk ^ rst_n;
        assign resp_out   = resp_in;
    end else begin : g_pipe
        logic  [STAGES-1:0] valid_q;
        logic  [STAGES-1:0] err_q;
        word_t [STAGES-1:0] data_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_q <= '0;
            end else begin
                valid_q[0] <= resp_in.valid;
                for (int i = 1; i < STAGES; i++) begin
                    valid_q[i] <= valid_q[i-1];
                end
            end
        end

        always_ff @(posedge clk) begin
            if (resp_in.valid) begin
                err_q[0]  <= resp_in.err;
                data_q[0] <= resp_in.data;
            end
            for (int i = 1; i < STAGES; i++) begin
                if (valid_q[i-1]) begin
                    err_q[i]  <= err_q[i-1];
                    data_q[i] <= data_q[i-1];
                end
            end
        end

        assign resp_out = {valid_q[STAGES-1], err_q[STAGES-1], data_q[STAGES-1]};
    end

endmodule

// File: rtl/instr_mem_bank.sv
// Instruction memory with req/gnt/rvalid fetch port, bounded outstanding reads and a load port.
module instr_mem_bank
    import instr_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS     = 1024,
    parameter int unsigned READ_LATENCY    = 1,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter logic [31:0] BASE_ADDR       = 32'h0,
    localparam int unsigned AW             = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          instr_req_i,
    input  logic [31:0]   instr_addr_i,
    output logic          instr_gnt_o,
    output logic          instr_rvalid_o,
    output logic [31:0]   instr_rdata_o,
    output logic          instr_err_o,
    input  logic          load_we_i,
    input  logic [AW-1:0] load_addr_i,
    input  logic [31:0]   load_wdata_i
);

    localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_OUTSTANDING);

    word_t           mem [DEPTH_WORDS];
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            gnt;
    logic            addr_err;
    logic [AW-1:0]   idx;
    imem_resp_t      rd_resp, pipe_resp;
    logic            rvalid_q, err_q;
    word_t           rdata_q;

    assign addr_err = imem_addr_err(instr_addr_i, BASE_ADDR, DEPTH_WORDS);
    assign idx      = AW'((instr_addr_i - BASE_ADDR) >> 2);
    // Load port wins over fetch so a write never races a read of the same cycle.
    assign gnt      = instr_req_i & ~load_we_i & (cnt_q < MaxCnt);

    always_ff @(posedge clk) begin
        if (load_we_i) begin
            mem[load_addr_i] <= load_wdata_i;
        end
    end

    always_comb begin
        rd_resp.valid = gnt;
        rd_resp.err   = addr_err;
        rd_resp.data  = addr_err ? '0 : mem[idx];
    end

    // The output register supplies the last latency stage.
    instr_mem_resp_pipe #(
        .STAGES (READ_LATENCY - 1)
    ) u_resp_pipe (
        .clk      (clk),
        .rst_n    (rst_n),
        .resp_in  (rd_resp),
        .resp_out (pipe_resp)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= pipe_resp.valid;
            if (pipe_resp.valid) begin
                err_q   <= pipe_resp.err;
                rdata_q <= pipe_resp.data;
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (gnt && !rvalid_q) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!gnt && rvalid_q) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign instr_gnt_o    = gnt;
    assign instr_rvalid_o = rvalid_q;
    assign instr_rdata_o  = rdata_q;
    assign instr_err_o    = err_q;

    a_cnt_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) cnt_q <= MaxCnt);
    a_cnt_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
                                         !(rvalid_q && cnt_q == '0));

endmodule

// File: tb/tb_instr_mem_bank.sv
// Scoreboard bench: three bank instances with different latency/outstanding/base settings.
module tb_instr_mem_bank;

    localparam int unsigned N = 3;

    logic        clk = 1'b0;
    logic        rst_n [N];
    logic        req   [N];
    logic [31:0] addr  [N];
    logic        gnt   [N];
    logic        rvalid[N];
    logic [31:0] rdata [N];
    logic        err   [N];
    logic        we    [N];
    logic [3:0]  la    [N];
    logic [31:0] wd    [N];

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    for (genvar k = 0; k < N; k++) begin : g_inst
        localparam int unsigned LAT  = (k == 0) ? 1 : (k == 1) ? 3 : 2;
        localparam int unsigned MAXO = (k == 1) ? 1 : 2;
        localparam logic [31:0] BASE = (k == 1) ? 32'h100 : 32'h0;

        instr_mem_bank #(
            .DEPTH_WORDS     (16),
            .READ_LATENCY    (LAT),
            .MAX_OUTSTANDING (MAXO),
            .BASE_ADDR       (BASE)
        ) u_dut (
            .clk            (clk),
            .rst_n          (rst_n[k]),
            .instr_req_i    (req[k]),
            .instr_addr_i   (addr[k]),
            .instr_gnt_o    (gnt[k]),
            .instr_rvalid_o (rvalid[k]),
            .instr_rdata_o  (rdata[k]),
            .instr_err_o    (err[k]),
            .load_we_i      (we[k]),
            .load_addr_i    (la[k]),
            .load_wdata_i   (wd[k])
        );

        logic [31:0] model_mem [16];
        logic [32:0] exp_q [$];
        int          gcyc_q [$];
        logic [32:0] last_rsp;

        always @(negedge clk) begin
            int          n;
            logic        exp_gnt;
            logic [32:0] e;
            logic [31:0] off;
            logic        bad;
            if (!rst_n[k]) begin
                exp_q.delete();
                gcyc_q.delete();
                last_rsp = '0;
                check_eq($sformatf("u%0d.rst_rvalid", k), 64'(rvalid[k]), 64'd0);
                check_eq($sformatf("u%0d.rst_rsp", k), 64'({err[k], rdata[k]}), 64'd0);
            end else begin
                n       = exp_q.size();
                exp_gnt = req[k] && !we[k] && (n < int'(MAXO));
                check_eq($sformatf("u%0d.gnt", k), 64'(gnt[k]), 64'(exp_gnt));
                if (rvalid[k]) begin
                    if (n == 0) begin
                        check_eq($sformatf("u%0d.unexpected_rvalid", k), 64'(rvalid[k]), 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check_eq($sformatf("u%0d.rsp", k), 64'({err[k], rdata[k]}), 64'(e));
                        check_eq($sformatf("u%0d.latency", k), 64'(cyc - gcyc_q.pop_front()),
                                 64'(LAT));
                        last_rsp = e;
                    end
                end else begin
                    check_eq($sformatf("u%0d.hold", k), 64'({err[k], rdata[k]}), 64'(last_rsp));
                end
                if (req[k] && gnt[k]) begin
                    off = addr[k] - BASE;
                    bad = (addr[k][1:0] != 2'b00) || (addr[k] < BASE) ||
                          (addr[k] >= BASE + 32'd64);
                    e   = bad ? {1'b1, 32'h0} : {1'b0, model_mem[off[5:2]]};
                    exp_q.push_back(e);
                    gcyc_q.push_back(cyc);
                end
                if (we[k]) model_mem[la[k]] = wd[k];
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int c);
        repeat (c) step();
    endtask

    task automatic load(input int k, input logic [3:0] a, input logic [31:0] d);
        we[k] = 1'b1;
        la[k] = a;
        wd[k] = d;
        step();
        we[k] = 1'b0;
    endtask

    task automatic fetch(input int k, input logic [31:0] a);
        int t;
        t       = 0;
        req[k]  = 1'b1;
        addr[k] = a;
        do begin
            @(negedge clk);
            t++;
        end while (!gnt[k] && t < 50);
        check_eq($sformatf("u%0d.fetch_granted", k), 64'(gnt[k]), 64'd1);
        step();
        req[k] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < N; k++) begin
            rst_n[k] = 1'b0;
            req[k]   = 1'b0;
            addr[k]  = '0;
            we[k]    = 1'b0;
            la[k]    = '0;
            wd[k]    = '0;
        end
        idle(3);
        for (int k = 0; k < N; k++) rst_n[k] = 1'b1;
        step();

        load(0, 0, 150);  load(0, 1, 3215);  load(0, 2, 2747);  load(0, 3, 251111);
        load(0, 5, 32'h1111);
        load(1, 0, 32'hA0);  load(1, 1, 32'hA1);  load(1, 2, 32'hA2);
        load(2, 0, 150);  load(2, 1, 3215);  load(2, 2, 2747);  load(2, 3, 251111);

        // Back-to-back fetches, LAT=1 MAX=2.
        fetch(0, 32'h0); fetch(0, 32'h4); fetch(0, 32'h8); fetch(0, 32'hC);
        idle(4);

        // LAT=3 MAX=1 with a held request, based at 0x100.
        fetch(1, 32'h100); fetch(1, 32'h104); fetch(1, 32'h108);
        idle(6);

        // Error responses then good reads.
        fetch(0, 32'h2); fetch(0, 32'd64); fetch(0, 32'h4);
        fetch(1, 32'hFC); fetch(1, 32'h140); fetch(1, 32'h100);
        idle(8);

        // Load collides with a pending request; the next grant sees the new word.
        req[0]  = 1'b1;
        addr[0] = 32'h14;
        we[0]   = 1'b1;
        la[0]   = 4'd5;
        wd[0]   = 32'hDEAD;
        step();
        we[0] = 1'b0;
        fetch(0, 32'h14);
        idle(4);

        // Reset with reads in flight on the LAT=2 instance.
        fetch(2, 32'h0);
        req[2]  = 1'b1;
        addr[2] = 32'h4;
        @(negedge clk);
        step();
        req[2]   = 1'b0;
        rst_n[2] = 1'b0;
        idle(3);
        rst_n[2] = 1'b1;
        step();
        fetch(2, 32'h8);
        idle(4);

        // Long held streams where grant and rvalid coincide at the limit.
        for (int i = 0; i < 20; i++) fetch(0, 32'(i % 4) * 4);
        for (int i = 0; i < 20; i++) fetch(2, 32'(i % 4) * 4);
        idle(8);

        check_eq("u0.drained", 64'(g_inst[0].exp_q.size()), 64'd0);
        check_eq("u1.drained", 64'(g_inst[1].exp_q.size()), 64'd0);
        check_eq("u2.drained", 64'(g_inst[2].exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
